// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with built-in 16x oversampling tick divider; one byte per tx_start/tx_done_tick handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
  parameter int BAUD_DIV   = 163,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic       top_clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_bus,
  output logic       tx_done_tick,
  output logic       tx,
  output logic       tx_busy
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              s_tick;
  logic              last_tick;
  logic              bit_done;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign s_tick = (div_cnt == DIV_W'(BAUD_DIV - 1));

  always_comb begin
    last_tick = (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    if (state == STOP) last_tick = (tick_cnt == TICK_W'(STOP_TICKS - 1));
  end

  assign bit_done = s_tick && last_tick;

  // Dropping ready in the same cycle as the request keeps a registered requester from double-issuing.
  assign tx_done_tick = (state == IDLE) && !tx_start && !rst;

  always_ff @(posedge top_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // Divider and tick counter only run inside a frame, so the first tick lands BAUD_DIV cycles after acceptance.
      if (state == IDLE || s_tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + DIV_W'(1);

      if (state == IDLE)  tick_cnt <= '0;
      else if (s_tick)    tick_cnt <= last_tick ? '0 : tick_cnt + TICK_W'(1);

      case (state)
        IDLE: begin
          if (tx_start) begin
            shift_reg  <= tx_bus;
            bit_idx    <= '0;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_bus;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx      <= shift_reg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
